// File: rtl/fp_norm_round.sv
// Normalize-and-round stage behind the FP adder datapath.
// Two-stage valid/ready pipeline: s1 normalizes, s2 rounds and packs.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    upstream handshake
//   in_sign              raw result sign
//   in_exp[E-1:0]        biased exponent of the hidden-bit position
//   in_mag[M+3:0]        {carry, hidden, frac[M-1:0], guard, sticky}
//   out_valid/out_ready  downstream handshake
//   out_sum[N-1:0]       packed {sign, exp, frac}
//   out_flags[2:0]       {overflow, underflow, inexact}
module fp_norm_round #(
  parameter int N = 32,
  localparam int E = N / 4,
  localparam int M = N - E - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [E-1:0] in_exp,
  input  logic [M+3:0] in_mag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic [2:0]   out_flags
);

  localparam int LW = $clog2(M + 3);
  localparam int EW = E + 1;
  localparam logic [EW-1:0] EMAX = {1'b0, {E{1'b1}}};

  // s1 state
  logic          r_s1_valid;
  logic          r_s1_fin;
  logic          r_s1_sign;
  logic [EW-1:0] r_s1_exp;
  logic [M-1:0]  r_s1_frac;
  logic          r_s1_g;
  logic          r_s1_s;
  logic [2:0]    r_s1_flg;

  // s2 state
  logic          r_s2_valid;
  logic [N-1:0]  r_sum;
  logic [2:0]    r_flg;

  logic          w_s2_adv;

  // ---------------- stage 1: normalize ----------------
  logic          w_spec;
  logic          w_zero;
  logic          w_carry;
  logic          w_flush;
  logic [LW-1:0] w_lzc;
  logic [M+2:0]  w_shl;
  logic [EW-1:0] w_exp_in;
  logic [EW-1:0] w_exp_c;
  logic [EW-1:0] w_exp_l;

  logic          w_n_fin;
  logic [EW-1:0] w_n_exp;
  logic [M-1:0]  w_n_frac;
  logic          w_n_g;
  logic          w_n_s;
  logic [2:0]    w_n_flg;

  // Leading-zero count from the hidden-bit position downward;
  // the highest set bit wins since it is visited last.
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i <= M + 2; i++) begin
      if (in_mag[i]) w_lzc = LW'(M + 2 - i);
    end
  end

  assign w_shl    = in_mag[M+2:0] << w_lzc;
  assign w_exp_in = {1'b0, in_exp};
  assign w_exp_c  = w_exp_in + EW'(1);
  assign w_exp_l  = w_exp_in - EW'(w_lzc);
  assign w_spec   = &in_exp;
  assign w_zero   = ~|in_mag;
  assign w_carry  = in_mag[M+3];
  assign w_flush  = w_exp_in <= EW'(w_lzc);

  // Final results (special, zero, flush) carry a ready packed word
  // through s1 and bypass rounding in s2.
  always_comb begin
    w_n_fin  = 1'b0;
    w_n_exp  = w_exp_l;
    w_n_frac = w_shl[M+1:2];
    w_n_g    = w_shl[1];
    w_n_s    = w_shl[0];
    w_n_flg  = 3'b000;
    if (w_spec) begin
      w_n_fin  = 1'b1;
      w_n_exp  = w_exp_in;
      w_n_frac = in_mag[M+1:2];
      w_n_g    = 1'b0;
      w_n_s    = 1'b0;
    end else if (w_zero) begin
      w_n_fin  = 1'b1;
      w_n_exp  = '0;
      w_n_frac = '0;
      w_n_g    = 1'b0;
      w_n_s    = 1'b0;
    end else if (w_carry) begin
      w_n_exp  = w_exp_c;
      w_n_frac = in_mag[M+2:3];
      w_n_g    = in_mag[2];
      w_n_s    = in_mag[1] | in_mag[0];
    end else if (w_flush) begin
      w_n_fin  = 1'b1;
      w_n_exp  = '0;
      w_n_frac = '0;
      w_n_g    = 1'b0;
      w_n_s    = 1'b0;
      w_n_flg  = 3'b011;
    end
  end

  // ---------------- stage 2: round ----------------
  logic          w_rnd;
  logic [M:0]    w_fsum;
  logic [EW-1:0] w_exp_r;
  logic          w_ovf;
  logic [N-1:0]  w_sum;
  logic [2:0]    w_flg;

  assign w_rnd   = r_s1_g & (r_s1_s | r_s1_frac[0]);
  assign w_fsum  = {1'b0, r_s1_frac} + (M+1)'(w_rnd);
  // Fraction carry-out leaves the low M bits at zero already.
  assign w_exp_r = r_s1_exp + EW'(w_fsum[M]);
  assign w_ovf   = w_exp_r >= EMAX;

  always_comb begin
    w_sum = {r_s1_sign, w_exp_r[E-1:0], w_fsum[M-1:0]};
    w_flg = {2'b00, r_s1_g | r_s1_s};
    if (r_s1_fin) begin
      w_sum = {r_s1_sign, r_s1_exp[E-1:0], r_s1_frac};
      w_flg = r_s1_flg;
    end else if (w_ovf) begin
      w_sum = {r_s1_sign, {E{1'b1}}, {M{1'b0}}};
      w_flg = 3'b101;
    end
  end

  // ---------------- handshake ----------------
  assign w_s2_adv  = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s2_adv;
  assign out_valid = r_s2_valid;
  assign out_sum   = r_sum;
  assign out_flags = r_flg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_fin   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
      r_s1_g     <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_flg   <= 3'b000;
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_flg      <= 3'b000;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_fin  <= w_n_fin;
          r_s1_sign <= in_sign;
          r_s1_exp  <= w_n_exp;
          r_s1_frac <= w_n_frac;
          r_s1_g    <= w_n_g;
          r_s1_s    <= w_n_s;
          r_s1_flg  <= w_n_flg;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_sum <= w_sum;
          r_flg <= w_flg;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round.
// Arithmetic reference model plus in-order scoreboard queue.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [2:0]  out_flags;

  fp_norm_round #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [34:0] q[$];
  bit          hold_chk = 1'b0;
  logic [34:0] held;
  bit          obs_v;
  logic [34:0] obs_d;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Returns {flags[2:0], sum[31:0]} computed with plain arithmetic.
  function automatic logic [34:0] model(input logic s,
                                        input logic [7:0] e,
                                        input logic [26:0] mag);
    longint m;
    longint frac;
    int     ex;
    int     lz;
    int     g;
    int     st;
    if (e == 8'd255) return {3'b000, s, 8'hFF, mag[24:2]};
    if (mag == 0) return {3'b000, s, 31'b0};
    m  = longint'(mag);
    ex = int'(e);
    if (m >= (64'd1 << 26)) begin
      m  = (m >> 1) | (m & 1);
      ex = ex + 1;
    end else begin
      lz = 0;
      while (m < (64'd1 << 25)) begin
        m  = m * 2;
        lz = lz + 1;
      end
      if (ex <= lz) return {3'b011, s, 31'b0};
      ex = ex - lz;
    end
    frac = (m >> 2) % (64'd1 << 23);
    g    = int'((m >> 1) & 1);
    st   = int'(m & 1);
    if (g != 0 && (st != 0 || (frac % 2) != 0)) frac = frac + 1;
    if (frac == (64'd1 << 23)) begin
      frac = 0;
      ex   = ex + 1;
    end
    if (ex >= 255) return {3'b101, s, 8'hFF, 23'b0};
    return {2'b00, 1'((g | st) != 0), s, 8'(ex), 23'(frac)};
  endfunction

  // One clock: drive at negedge, sample 1 unit later, score the edge.
  task automatic cycle(input bit iv, input logic s,
                       input logic [7:0] e, input logic [26:0] m,
                       input bit ordy, output bit acc);
    logic [34:0] cur;
    @(negedge clk);
    in_valid  = iv;
    in_sign   = s;
    in_exp    = e;
    in_mag    = m;
    out_ready = ordy;
    #1;
    cur   = {out_flags, out_sum};
    obs_v = out_valid;
    obs_d = cur;
    if (hold_chk) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(cur), 64'(held));
    end
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else if (ordy) chk("data", 64'(cur), 64'(q.pop_front()));
    end
    hold_chk = out_valid && !ordy;
    held     = cur;
    acc      = iv && in_ready;
    if (acc) q.push_back(model(s, e, m));
  endtask

  task automatic rand_word(output logic s, output logic [7:0] e,
                           output logic [26:0] m);
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       e = 8'd255;
      1:       e = 8'd254;
      2:       e = 8'($urandom_range(0, 30));
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 7))
      0:       m = '0;
      1:       m = 27'h3FFFFFC | 27'($urandom_range(0, 3));
      default: m = 27'($urandom) >> $urandom_range(0, 26);
    endcase
  endtask

  // Single word into an empty pipe: checks 2-cycle latency and value.
  task automatic direct(input string tag, input logic s,
                        input logic [7:0] e, input logic [26:0] m,
                        input logic [34:0] exp);
    bit acc;
    cycle(1'b1, s, e, m, 1'b1, acc);
    chk("accept", 64'(acc), 64'd1);
    cycle(1'b0, 1'b0, 8'd0, 27'd0, 1'b1, acc);
    chk("lat_early", 64'(obs_v), 64'd0);
    cycle(1'b0, 1'b0, 8'd0, 27'd0, 1'b1, acc);
    chk("lat_valid", 64'(obs_v), 64'd1);
    chk(tag, 64'(obs_d), 64'(exp));
  endtask

  // mode 0: out_ready low 3 cycles, 1: toggling, 2: random.
  task automatic stream(input int nwords, input int mode,
                        input int maxc);
    int          sent = 0;
    int          c = 0;
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    bit          acc;
    bit          ordy;
    rand_word(s, e, m);
    while ((sent < nwords || q.size() > 0) && c < maxc) begin
      case (mode)
        0:       ordy = (c >= 3);
        1:       ordy = c[0];
        default: ordy = 1'($urandom_range(0, 1));
      endcase
      cycle(sent < nwords, s, e, m, ordy, acc);
      if (acc) begin
        sent++;
        rand_word(s, e, m);
      end
      c++;
    end
    chk("drained", 64'(q.size()), 64'd0);
    chk("sent", 64'(sent), 64'(nwords));
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mag    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    rst = 1'b0;

    direct("carry_only", 1'b0, 8'd127, 27'h4000000, {3'b000, 32'h40000000});
    direct("half", 1'b0, 8'd127, 27'h1000000, {3'b000, 32'h3F000000});
    direct("neg_zero", 1'b1, 8'd127, 27'd0, {3'b000, 32'h80000000});
    direct("tie_even", 1'b0, 8'd127, 27'h2000002, {3'b001, 32'h3F800000});
    direct("tie_odd", 1'b0, 8'd127, 27'h2000006, {3'b001, 32'h3F800002});
    direct("rnd_carry", 1'b0, 8'd127, 27'h3FFFFFE, {3'b001, 32'h40000000});
    direct("overflow", 1'b0, 8'd254, 27'h4000000, {3'b101, 32'h7F800000});
    direct("underflow", 1'b0, 8'd3, 27'h0200000, {3'b011, 32'h00000000});
    direct("special", 1'b0, 8'd255, 27'h2000014, {3'b000, 32'h7F800005});

    stream(4, 0, 100);
    stream(20, 1, 200);
    stream(300, 2, 5000);

    // Reset with both stages occupied.
    cycle(1'b1, 1'b0, 8'd100, 27'h2345678, 1'b0, acc);
    cycle(1'b1, 1'b1, 8'd90, 27'h1234567, 1'b0, acc);
    chk("fill_two", 64'(q.size()), 64'd2);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_sum", 64'(out_sum), 64'd0);
    chk("arst_out_flags", 64'(out_flags), 64'd0);
    q.delete();
    hold_chk = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    direct("post_rst", 1'b1, 8'd127, 27'h2000000, {3'b000, 32'hBF800000});
    cycle(1'b0, 1'b0, 8'd0, 27'd0, 1'b1, acc);
    chk("post_rst_empty", 64'(obs_v), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
